// File: rtl/adc_cap_pkg.sv
// Shared types and defaults for the triggered ADC capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_cap_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 16;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } cap_state_t;

endpackage

// File: rtl/adc_cap_ram.sv
// Capture buffer: DEPTH x DW distributed RAM, one sync write port, one async read port.
// Latency: write lands on the clock edge; read data follows rd_addr combinationally.
// Backpressure: none; the owner decides when to write and where to read.
module adc_cap_ram #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    // Contents are deliberately left unreset so this maps onto LUT RAM.
    logic [DW-1:0] mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adc_trig_capture.sv
// Rising-edge triggered ADC capture of DEPTH samples, then a valid/ready readout stream.
// Latency: first word is valid the cycle after the final write; the trigger sample lands at address 0 on its own cycle.
// Backpressure: rd_ready=0 holds rd_data/rd_valid/rd_last; the capture side never stalls the ADC.
module adc_trig_capture
    import adc_cap_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk_pin_p,
    input  logic             rst_pin,
    input  logic [DW-1:0]    sample_in,
    input  logic             sample_vld,
    input  logic [DW-1:0]    thresh,
    input  logic             arm,
    input  logic             abort,
    output logic [DW-1:0]    rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             rd_last,
    output logic             busy,
    output logic [CNT_W-1:0] cap_count
);

    localparam int            AW          = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PENULT_ADDR = AW'(DEPTH - 2);

    cap_state_t    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] prev_sample;
    logic [DW-1:0] ram_q;
    logic          prev_vld;
    logic          trig;
    logic          wr_en;

    // Upward crossing of thresh; needs a previous sample from this arming.
    assign trig = (state == ST_ARMED) && sample_vld && prev_vld &&
                  (prev_sample < thresh) && (sample_in >= thresh);

    // Abort wins over a write in the same cycle.
    assign wr_en   = !abort && sample_vld && (trig || (state == ST_CAPTURE));
    assign wr_addr = (state == ST_CAPTURE) ? wr_ptr : '0;

    // Zero when not presenting a word, so reset forces rd_data low immediately.
    assign rd_data = rd_valid ? ram_q : '0;

    adc_cap_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk_pin_p),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (sample_in),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // Capture FSM with pointers, trigger history and registered status outputs.
    always_ff @(posedge clk_pin_p or negedge rst_pin) begin
        if (!rst_pin) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            prev_sample <= '0;
            prev_vld    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            busy        <= 1'b0;
            cap_count   <= '0;
        end else if (abort) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            prev_vld <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state    <= ST_ARMED;
                        prev_vld <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (sample_vld) begin
                        prev_sample <= sample_in;
                        prev_vld    <= 1'b1;
                        if (trig) begin
                            wr_ptr <= AW'(1);
                            state  <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (sample_vld) begin
                        if (wr_ptr == LAST_ADDR) begin
                            wr_ptr   <= '0;
                            rd_ptr   <= '0;
                            rd_valid <= 1'b1;
                            rd_last  <= 1'b0;
                            state    <= ST_READOUT;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                ST_READOUT: begin
                    if (rd_ready) begin
                        if (rd_last) begin
                            state    <= ST_IDLE;
                            rd_ptr   <= '0;
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            busy     <= 1'b0;
                            if (cap_count != '1) begin
                                cap_count <= cap_count + 1'b1;
                            end
                        end else begin
                            rd_ptr  <= rd_ptr + 1'b1;
                            rd_last <= (rd_ptr == PENULT_ADDR);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
